// File: rtl/imem_loader.sv
// imem_loader: writer side of the processor's byte-wide instruction memory.
// Takes 32-bit program words from a valid/ready stream and writes each one
// big-endian, one byte per cycle, into imem. The processor is held in reset
// until the final word has been written, then released so that instruction
// fetch starts from address 0.
//
// Parameters:
//   ADDR_W     imem byte-address width
//   DEPTH      imem size in bytes (multiple of 4, <= 2**ADDR_W)
//   BASE_ADDR  first byte address written (word aligned)
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   in_valid     a program word is presented
//   in_ready     loader can take a word this cycle
//   in_word      instruction word; [31:24] lands at the lowest byte address
//   in_last      marks in_word as the final word of the program
//   mem_we       byte write strobe to imem
//   mem_addr     byte address
//   mem_wdata    byte data
//   cpu_reset    processor reset, 1 while loading
//   load_done    program written, processor released
//   overflow_err sticky, a word arrived after imem was full
//   checksum     XOR of all written words (only with IMEM_LOADER_CHECKSUM_EN)
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//
// State    | meaning
// S_WAIT   | ready for the next word
// S_WRITE  | emitting the four bytes of the latched word
// S_DONE   | program loaded, processor released; terminal until reset

module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              overflow_err
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {S_WAIT, S_WRITE, S_DONE} state_t;

  // One past the highest byte address imem may receive.
  localparam logic [ADDR_W+1:0] LIMIT = (ADDR_W+2)'(BASE_ADDR + DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr;
  logic [1:0]        k;
  logic [31:0]       shreg;
  logic              last_q;
  logic              accept, room, write_word, drop_word, final_byte;

  always_comb begin
    accept     = in_valid && in_ready;
    // ptr is one bit wider than mem_addr so a completely full imem is
    // distinguishable from an empty one.
    room       = ({1'b0, ptr} + (ADDR_W+2)'(4)) <= LIMIT;
    write_word = accept && room;
    drop_word  = accept && !room;
    final_byte = (state == S_WRITE) && (k == 2'd3);
    state_nxt  = state;
    case (state)
      S_WAIT: begin
        if (write_word)                 state_nxt = S_WRITE;
        else if (drop_word && in_last)  state_nxt = S_DONE;
      end
      S_WRITE: begin
        if (final_byte) state_nxt = last_q ? S_DONE : S_WAIT;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT;
    else       state <= state_nxt;
  end

  // All visible outputs are registered and track state_nxt, so they change
  // on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
      ptr          <= (ADDR_W+1)'(BASE_ADDR);
      k            <= '0;
      shreg        <= '0;
      last_q       <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == S_WAIT);
      cpu_reset <= (state_nxt != S_DONE);
      load_done <= (state_nxt == S_DONE);
      if (drop_word) overflow_err <= 1'b1;

      if (write_word) begin
        // Byte 0 goes out on the accept edge; the rest shift out of shreg.
        mem_we    <= 1'b1;
        mem_addr  <= ptr[ADDR_W-1:0];
        mem_wdata <= in_word[31:24];
        shreg     <= {in_word[23:0], 8'h00};
        last_q    <= in_last;
        k         <= '0;
      end else if (state == S_WRITE) begin
        if (final_byte) begin
          mem_we <= 1'b0;
          ptr    <= ptr + (ADDR_W+1)'(4);
        end else begin
          k         <= k + 2'd1;
          mem_addr  <= mem_addr + ADDR_W'(1);
          mem_wdata <= shreg[31:24];
          shreg     <= {shreg[23:0], 8'h00};
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)           checksum <= '0;
    else if (write_word) checksum <= checksum ^ in_word;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a cycle-level
// expectation model (a schedule queue of byte writes) checked every cycle,
// plus literal expectations for the documented scenarios.
// Optional feature macro exercised when defined: IMEM_LOADER_CHECKSUM_EN

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_ready, mem_we, cpu_reset, load_done, overflow_err;
  logic [7:0]  mem_addr, mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  imem_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .overflow_err(overflow_err)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: the queue holds the exact per-cycle byte writes still owed.
  logic [7:0]  q_addr[$];
  logic [7:0]  q_data[$];
  int          m_words = 0;
  bit          m_done = 0, m_ovf = 0, last_pend = 0, ovf_pend = 0;
  logic [31:0] m_csum = '0;
  bit          rst_seen = 1'b1;
  bit          prev_ld = 1'b0;
  int          cyc = 0, hs_cyc = 0, done_cyc = 0, wr_count = 0, max_addr = 0;
  logic [7:0]  dut_mem[256];
  bit          written[256];

  always @(posedge clk) rst_seen <= reset;

  always @(negedge clk) begin : cmp
    bit         exp_ready;
    logic [7:0] ea, ed;
    cyc++;
    if (rst_seen) begin
      q_addr.delete();
      q_data.delete();
      m_words = 0; m_done = 0; m_ovf = 0; last_pend = 0; ovf_pend = 0;
      m_csum = '0; prev_ld = 0;
      check("rst_in_ready", in_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_load_done", load_done, 0);
      check("rst_overflow", overflow_err, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("rst_checksum", checksum, 0);
`endif
    end else begin
      if (ovf_pend) m_ovf = 1;
      ovf_pend = 0;
      if (last_pend && q_addr.size() == 0) begin
        m_done = 1;
        last_pend = 0;
      end
      exp_ready = !m_done && (q_addr.size() == 0);
      check("in_ready", in_ready, exp_ready);
      check("mem_we", mem_we, q_addr.size() != 0);
      if (q_addr.size() != 0) begin
        ea = q_addr.pop_front();
        ed = q_data.pop_front();
        check("mem_addr", mem_addr, ea);
        check("mem_wdata", mem_wdata, ed);
      end
      check("cpu_reset", cpu_reset, !m_done);
      check("load_done", load_done, m_done);
      check("overflow_err", overflow_err, m_ovf);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("checksum", checksum, m_csum);
`endif
      if (mem_we === 1'b1) begin
        wr_count++;
        dut_mem[mem_addr] = mem_wdata;
        written[mem_addr] = 1'b1;
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      end
      if (load_done === 1'b1 && !prev_ld) done_cyc = cyc;
      prev_ld = (load_done === 1'b1);
      if (in_valid && exp_ready && !reset) begin
        hs_cyc = cyc;
        if (m_words < 64) begin
          for (int b = 0; b < 4; b++) begin
            q_addr.push_back(8'(4 * m_words + b));
            q_data.push_back(in_word[31 - 8*b -: 8]);
          end
          m_words++;
          m_csum = m_csum ^ in_word;
        end else begin
          ovf_pend = 1;
        end
        if (in_last) last_pend = 1;
      end
    end
  end

  // Stimulus tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    int n;
    in_valid = 1'b1;
    in_word = w;
    in_last = l;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (load_done !== 1'b1) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  int   first_hs;
  bit   found;
  logic [31:0] w;

  initial begin
    do_reset();
    check("init_cpu_reset", cpu_reset, 1);
    check("init_load_done", load_done, 0);

    // Single-word program
    wr_count = 0;
    send_word(32'h8C220004, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done();
    check("t1_latency", done_cyc - hs_cyc, 5);
    check("t1_writes", wr_count, 4);
    check("t1_b0", dut_mem[0], 8'h8C);
    check("t1_b1", dut_mem[1], 8'h22);
    check("t1_b2", dut_mem[2], 8'h00);
    check("t1_b3", dut_mem[3], 8'h04);

    // Three back-to-back words with in_valid held high
    do_reset();
    wr_count = 0;
    send_word(32'h20010005, 1'b0);
    first_hs = hs_cyc;
    send_word(32'h20020003, 1'b0);
    send_word(32'h00221820, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done();
    check("t2_latency", done_cyc - first_hs, 15);
    check("t2_writes", wr_count, 12);
    check("t2_b4", dut_mem[4], 8'h20);
    check("t2_b7", dut_mem[7], 8'h03);
    check("t2_b10", dut_mem[10], 8'h18);
    check("t2_b11", dut_mem[11], 8'h20);

    // Fill imem exactly, then one extra word marked last
    do_reset();
    wr_count = 0;
    max_addr = 0;
    for (int i = 0; i < 64; i++) begin
      w = {8'(i), ~8'(i), 8'h5A, 8'(i)};
      send_word(w, 1'b0);
    end
    send_word(32'hDEADBEEF, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done();
    check("t3_writes", wr_count, 256);
    check("t3_max_addr", max_addr, 255);
    check("t3_overflow", overflow_err, 1);
    check("t3_load_done", load_done, 1);
    check("t3_b253", dut_mem[253], 8'hC0);
    check("t3_b255", dut_mem[255], 8'h3F);

    // Traffic while already done is ignored
    in_valid = 1'b1;
    in_word = 32'h12345678;
    in_last = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("t5_writes", wr_count, 256);
    check("t5_overflow", overflow_err, 1);
    check("t5_in_ready", in_ready, 0);
    in_valid = 1'b0; in_last = 1'b0;

    // Reset during byte 2 of the second word, then reload
    do_reset();
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    wr_count = 0;
    send_word(32'h11223344, 1'b0);
    in_word = 32'h55667788;
    in_last = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (mem_we === 1'b1 && mem_addr == 8'd6) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("t4_byte2_timeout", 0, 1);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t4_written6", written[6], 1);
    check("t4_written7", written[7], 0);
    check("t4_b6", dut_mem[6], 8'h77);
    check("t4_writes", wr_count, 7);
    check("t4_cpu_reset", cpu_reset, 1);
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    wr_count = 0;
    send_word(32'hFFFFFFFF, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done();
    for (int i = 0; i < 4; i++) check("t4_reload_byte", dut_mem[i], 8'hFF);
    check("t4_reload_writes", wr_count, 4);
    check("t4_written4", written[4], 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    send_word(32'h12345678, 1'b0);
    send_word(32'h0F0F0F0F, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done();
    check("t6_checksum", checksum, 32'h1D3B5977);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
